cdc_fifo_read_arb: RTL



---
 rtl/cdc_fifo_read_arb_if.sv | 34 +++
 rtl/cdc_fifo_read_arb.sv | 106 ++++++++++
 2 files changed

// File: rtl/cdc_fifo_read_arb_if.sv
// cdc_fifo_read_arb_if: FIFO read-side and output stream bundle for cdc_fifo_read_arb
// Parameters: NUM_CH FIFO read sides, DATA_WIDTH word width.
// Signals:
//   ch_empty  per-FIFO r_empty (bit i is FIFO i)
//   ch_data   per-FIFO read data, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_inc    per-FIFO r_inc, one-hot or zero
//   m_valid/m_ready/m_data/m_chan  registered output stream tagged with source channel
//   busy      arbiter is inside a burst
// Modports: master = arbiter side, slave = FIFOs plus downstream sink.
interface cdc_fifo_read_arb_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 8
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]            ch_empty;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_inc;
    logic                         m_valid;
    logic                         m_ready;
    logic [DATA_WIDTH-1:0]        m_data;
    logic [CW-1:0]                m_chan;
    logic                         busy;

    modport master (
        input  ch_empty, ch_data, m_ready,
        output ch_inc, m_valid, m_data, m_chan, busy
    );

    modport slave (
        output ch_empty, ch_data, m_ready,
        input  ch_inc, m_valid, m_data, m_chan, busy
    );
endinterface

// File: rtl/cdc_fifo_read_arb.sv
// cdc_fifo_read_arb: round-robin burst arbiter sharing one stream sink between NUM_CH CDC FIFO read sides
// Ports:
//   clk    read-domain clock shared by all FIFO read sides
//   reset  asynchronous active-high reset
//   bus    cdc_fifo_read_arb_if.master (ch_empty/ch_data/ch_inc, m_valid/m_ready/m_data/m_chan, busy)
// Parameters: NUM_CH (2..8), DATA_WIDTH, BURST_LEN (1..256) words per grant.
// Option: define CDC_FIFO_READ_ARB_STRICT_PRIO_EN to pick the lowest-index non-empty
// channel in IDLE instead of round-robin.
module cdc_fifo_read_arb #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    cdc_fifo_read_arb_if.master    bus
);
    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNTW = $clog2(BURST_LEN) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   pick;
    logic            any;
    logic            slot_free;
    logic            pop;
    logic            done;
    logic            rel;

    // Output slot can take a word when empty or being drained this cycle.
    assign slot_free = !bus.m_valid || bus.m_ready;
    assign pop       = (state_q == BURST) && slot_free && !bus.ch_empty[grant_q];
    assign done      = pop && (cnt_q == CNTW'(BURST_LEN - 1));
    // Early release only when the slot is free, so backpressure never drops the grant.
    assign rel       = bus.ch_empty[grant_q] && slot_free;
    assign bus.ch_inc = pop ? (NUM_CH'(1) << grant_q) : '0;
    assign bus.busy   = (state_q == BURST);

    // Descending scan with overwrite leaves the first hit of the ascending order.
    always_comb begin
        pick = '0;
        any  = 1'b0;
`ifdef CDC_FIFO_READ_ARB_STRICT_PRIO_EN
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!bus.ch_empty[k]) begin
                pick = CW'(k);
                any  = 1'b1;
            end
        end
`else
        for (int k = NUM_CH; k >= 1; k--) begin
            if (!bus.ch_empty[(int'(last_q) + k) % NUM_CH]) begin
                pick = CW'((int'(last_q) + k) % NUM_CH);
                any  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (any) begin
                grant_d = pick;
                cnt_d   = '0;
                state_d = BURST;
            end
        end else begin
            if (pop)
                cnt_d = cnt_q + CNTW'(1);
            if (done || rel) begin
                state_d = IDLE;
                last_d  = grant_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= CW'(NUM_CH - 1);
            cnt_q       <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_chan  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            bus.m_valid <= pop || (bus.m_valid && !bus.m_ready);
            if (pop) begin
                bus.m_data <= bus.ch_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                bus.m_chan <= grant_q;
            end
        end
    end
endmodule
